bp_upsizer: RTL and testbench
=============================

// Module: bp_upsizer
// PURPOSE
//  Ready/valid width upsizer: packs RATIO consecutive IN_W-bit beats into one IN_W*RATIO word.
//  Sits directly upstream of bp_pipe, feeding wide operand words to the array input pipeline.
//  last_i closes a partial word early; strb_o flags which lanes hold beats of the current word.
// PARAMETERS
//  IN_W   8  bits per input beat
//  RATIO  4  input beats per output word; >=2, power of two not required
// PORTS
//  clk_i    in   1           clock, all state on rising edge
//  rst_i    in   1           reset, synchronous, active-high
//  data_i   in   IN_W        input beat
//  valid_i  in   1           input beat valid
//  last_i   in   1           beat is last of packet; closes word; qualified by valid_i
//  ready_o  out  1           block accepts beat this cycle
//  data_o   out  IN_W*RATIO  packed word; beat k of word in lane k = data_o[k*IN_W +: IN_W]
//  strb_o   out  RATIO       lane k holds a beat of this word
//  last_o   out  1           word was closed by last_i
//  valid_o  out  1           output word valid
//  ready_i  in   1           downstream (bp_pipe ready_o) accepts word
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high. While rst_i=1 ready_o=0. After reset: valid_o=0,
//    data_o=0, strb_o=0, last_o=0, lane counter=0, accumulator=0; ready_o=1 from first cycle after.
//    Reset mid-word discards the partial word and any held output word, no output produced.
//  - Beat accepted iff valid_i && ready_o. ready_o = !rst_i && (!valid_o || ready_i); combinational
//    ready_i->ready_o only; no valid_i->ready_o or last_i->ready_o path.
//  - Lane counter cnt (width $clog2(RATIO)): accepted beat written to lane cnt of accumulator.
//  - Word closes when accepted beat has cnt==RATIO-1 or last_i=1. On close, in the same edge:
//    data_o <= accumulator lanes [0..cnt-1] with data_i in lane cnt; strb_o <= lanes 0..cnt set;
//    last_o <= last_i; valid_o <= 1; cnt <= 0. Non-closing beat: cnt <= cnt+1, valid_o unaffected.
//  - Latency: valid_o asserts the cycle after the closing beat is accepted.
//  - Output held stable (data_o, strb_o, last_o, valid_o) while valid_o && !ready_i (AXI-style).
//  - valid_o && ready_i with no closing beat: valid_o <= 0. Simultaneous consume and closing beat:
//    new word loaded, valid_o stays 1 (full throughput: one word per RATIO cycles, no bubble).
//  - Filling stalls (ready_o=0) only while output word is held and ready_i=0.
//  - last_i at cnt==RATIO-1: single full word, strb_o all ones, last_o=1.
//  - last_i at cnt==0: one-beat word, strb_o = 'b1.
//  - Lanes above cnt in a partial word: see CONFIGURATION. strb_o/last_o always exact.
//  - Elaboration assertion: RATIO>=2, IN_W>=1.
// CONFIGURATION
//  BP_UPSIZER_ZERO_FILL_EN defined: accumulator cleared to 0 whenever a word closes; lanes with
//    strb_o=0 of a partial word read exactly 0.
//  Not defined: accumulator never cleared after reset; lanes with strb_o=0 carry the value last
//    written to that lane (deterministic stale data); saves the clear mux.
// TESTING
//  1 RATIO=4, ready_i=1, beats 0x11,0x22,0x33,0x44 back-to-back -> one cycle after 4th beat
//    data_o=0x44332211, strb_o=4'b1111, last_o=0, valid_o=1 for exactly one cycle.
//  2 Continuous 16 beats, ready_i=1 -> 4 words, ready_o never drops, valid_o pulses every 4 cycles.
//  3 Word pending, ready_i=0 for 5 cycles, valid_i=1 -> ready_o=0, outputs stable 5 cycles;
//    ready_i=1 -> word consumed, next beats accepted same cycle.
//  4 Beats 0xAA,0xBB with last_i on 2nd -> data_o[15:0]=0xBBAA, strb_o=4'b0011, last_o=1;
//    with ZERO_FILL_EN upper 16 bits=0, without: upper lanes equal prior word's lanes 2,3.
//  5 Closing beat accepted in same cycle old word consumed -> valid_o stays 1, new word, no bubble.
//  6 Assert rst_i after 2 beats of a word -> ready_o=0 during reset; after: valid_o=0, next 4 beats
//    form a fresh word starting at lane 0.

Source files
------------

// File: rtl/bp_upsizer_if.sv
// Ready/valid bundle between a narrow beat source, the bp_upsizer packer and
// its wide-word sink. The packer takes the slave view; the environment driving
// beats in and taking words out takes the master view.
interface bp_upsizer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  // narrow input side
  logic [IN_W-1:0]       data_i;
  logic                  valid_i;
  logic                  last_i;
  logic                  ready_o;
  // wide output side
  logic [IN_W*RATIO-1:0] data_o;
  logic [RATIO-1:0]      strb_o;
  logic                  last_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, strb_o, last_o, valid_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, strb_o, last_o, valid_o
  );
endinterface

// File: rtl/bp_upsizer.sv
// Ready/valid width upsizer: packs RATIO consecutive IN_W-bit beats into one
// IN_W*RATIO-bit word, lane k = data_o[k*IN_W +: IN_W]. last_i closes a
// partial word early; strb_o marks the lanes that hold beats of the word.
// Optional feature macro: BP_UPSIZER_ZERO_FILL_EN -- when defined the
// accumulator is cleared whenever a word closes, so unused lanes of a partial
// word read 0; otherwise they carry stale (last written) lane data.
module bp_upsizer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  bp_upsizer_if.slave bus
);

  localparam int              CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0]   LAST_LANE = CW'(RATIO - 1);

  typedef logic [RATIO-1:0][IN_W-1:0] word_t;

  // Reject configurations the packer cannot represent.
  if (RATIO < 2 || IN_W < 1) begin : g_bad_param
    $error("bp_upsizer: requires RATIO>=2 and IN_W>=1");
  end

  logic [CW-1:0]    cnt;
  word_t            acc;
  word_t            word_q;
  logic [RATIO-1:0] strb_q;
  logic             last_q;
  logic             valid_q;

  logic             ready;
  logic             accept;
  logic             close;
  word_t            word_next;
  logic [RATIO-1:0] strb_next;

  // Accept while the output register is empty or being drained this cycle;
  // only ready_i (never valid_i/last_i) reaches ready_o combinationally.
  assign ready  = !rst_i && (!valid_q || bus.ready_i);
  assign accept = bus.valid_i && ready;
  assign close  = accept && (bus.last_i || cnt == LAST_LANE);

  // Word as it would leave on a closing beat: accumulator with data_i merged
  // into the current lane, strobes set for lanes 0..cnt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
    word_next      = acc;
    word_next[cnt] = bus.data_i;
    strb_next      = '0;
    for (int k = 0; k < RATIO; k++) begin
      strb_next[k] = (CW'(k) <= cnt);
    end
  end

  // Lane counter, accumulator and the held output word.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      cnt     <= '0;
      acc     <= '0;
      word_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
`ifdef BP_UPSIZER_ZERO_FILL_EN
        if (close) acc <= '0;
        else       acc[cnt] <= bus.data_i;
`else
        acc[cnt] <= bus.data_i;
`endif
        cnt <= close ? '0 : cnt + 1'b1;
      end

      if (close) begin
        word_q  <= word_next;
        strb_q  <= strb_next;
        last_q  <= bus.last_i;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.data_o  = word_q;
  assign bus.strb_o  = strb_q;
  assign bus.last_o  = last_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_bp_upsizer.sv
// Directed bench for bp_upsizer (IN_W=8, RATIO=4). Expectations for
// partial-word upper lanes follow BP_UPSIZER_ZERO_FILL_EN when defined.
module tb_bp_upsizer;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  bp_upsizer_if #(.IN_W(8), .RATIO(4)) bus ();

  bp_upsizer #(.IN_W(8), .RATIO(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic l);
    bus.data_i  = d;
    bus.valid_i = v;
    bus.last_i  = l;
  endtask

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input logic [3:0] s,
                            input logic l);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    check({tag, ".data"},  bus.data_o, d);
    check({tag, ".strb"},  32'(bus.strb_o), 32'(s));
    check({tag, ".last"},  32'(bus.last_o), 32'(l));
  endtask

  logic [31:0] exp_w;
  logic [31:0] held;

  initial begin
    rst_i       = 1'b1;
    bus.ready_i = 1'b1;
    drive(8'h00, 1'b0, 1'b0);

    // reset
    tick();
    check("rst.ready_during", 32'(bus.ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("rst.valid", 32'(bus.valid_o), 32'd0);
    check("rst.data",  bus.data_o, 32'd0);
    check("rst.strb",  32'(bus.strb_o), 32'd0);
    check("rst.last",  32'(bus.last_o), 32'd0);
    check("rst.ready", 32'(bus.ready_o), 32'd1);

    // test 1: four beats back to back
    drive(8'h11, 1'b1, 1'b0); tick(); check("t1.b1.valid", 32'(bus.valid_o), 32'd0);
    drive(8'h22, 1'b1, 1'b0); tick(); check("t1.b2.valid", 32'(bus.valid_o), 32'd0);
    drive(8'h33, 1'b1, 1'b0); tick(); check("t1.b3.valid", 32'(bus.valid_o), 32'd0);
    drive(8'h44, 1'b1, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b0);
    check_word("t1.word", 32'h44332211, 4'b1111, 1'b0);
    tick();
    check("t1.one_cycle", 32'(bus.valid_o), 32'd0);

    // test 2: 16 continuous beats
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 1'b1, 1'b0);
      #1;
      check($sformatf("t2.ready%0d", i), 32'(bus.ready_o), 32'd1);
      tick();
      if (i % 4 == 3) begin
        exp_w = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
        check_word($sformatf("t2.word%0d", i / 4), exp_w, 4'b1111, 1'b0);
      end else begin
        check($sformatf("t2.idle%0d", i), 32'(bus.valid_o), 32'd0);
      end
    end
    drive(8'h00, 1'b0, 1'b0);
    tick();
    check("t2.drain", 32'(bus.valid_o), 32'd0);

    // test 3: backpressure holds the word and stalls filling
    bus.ready_i = 1'b0;
    drive(8'hA1, 1'b1, 1'b0); tick();
    drive(8'hA2, 1'b1, 1'b0); tick();
    drive(8'hA3, 1'b1, 1'b0); tick();
    drive(8'hA4, 1'b1, 1'b0); tick();
    check_word("t3.held", 32'hA4A3A2A1, 4'b1111, 1'b0);
    drive(8'hB1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3.stall%0d", i), 32'(bus.ready_o), 32'd0);
      tick();
      check($sformatf("t3.hold_data%0d", i), bus.data_o, 32'hA4A3A2A1);
      check($sformatf("t3.hold_valid%0d", i), 32'(bus.valid_o), 32'd1);
    end
    bus.ready_i = 1'b1;
    #1;
    check("t3.release_ready", 32'(bus.ready_o), 32'd1);
    tick();
    check("t3.consumed", 32'(bus.valid_o), 32'd0);
    drive(8'hB2, 1'b1, 1'b0); tick();
    drive(8'hB3, 1'b1, 1'b0); tick();
    drive(8'hB4, 1'b1, 1'b0); tick();
    check_word("t3.next", 32'hB4B3B2B1, 4'b1111, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    tick();

    // test 4: partial word closed by last_i on the second beat
    drive(8'hAA, 1'b1, 1'b0); tick();
    drive(8'hBB, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0);
`ifdef BP_UPSIZER_ZERO_FILL_EN
    check_word("t4.partial", 32'h0000BBAA, 4'b0011, 1'b1);
`else
    check_word("t4.partial", 32'hB4B3BBAA, 4'b0011, 1'b1);
`endif
    tick();

    // one-beat word: last_i at lane 0
    drive(8'hCC, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0);
`ifdef BP_UPSIZER_ZERO_FILL_EN
    check_word("t4.one_beat", 32'h000000CC, 4'b0001, 1'b1);
`else
    check_word("t4.one_beat", 32'hB4B3BBCC, 4'b0001, 1'b1);
`endif
    tick();

    // last_i on the final lane: full word with last_o
    drive(8'h01, 1'b1, 1'b0); tick();
    drive(8'h02, 1'b1, 1'b0); tick();
    drive(8'h03, 1'b1, 1'b0); tick();
    drive(8'h04, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0);
    check_word("t4.full_last", 32'h04030201, 4'b1111, 1'b1);
    tick();

    // test 5: closing beat in the same cycle the old word is consumed
    drive(8'hD1, 1'b1, 1'b1); tick();
    check("t5.w1.lane0", 32'(bus.data_o[7:0]), 32'hD1);
    drive(8'hD2, 1'b1, 1'b1); tick();
    check("t5.w2.valid", 32'(bus.valid_o), 32'd1);
    check("t5.w2.lane0", 32'(bus.data_o[7:0]), 32'hD2);
    check("t5.w2.strb",  32'(bus.strb_o), 32'h1);
    bus.ready_i = 1'b0;
    drive(8'hD3, 1'b1, 1'b1);
    #1;
    check("t5.stall", 32'(bus.ready_o), 32'd0);
    tick();
    held = bus.data_o;
    check("t5.hold", 32'(held[7:0]), 32'hD2);
    bus.ready_i = 1'b1;
    tick();
    check("t5.w3.valid", 32'(bus.valid_o), 32'd1);
    check("t5.w3.lane0", 32'(bus.data_o[7:0]), 32'hD3);
    drive(8'h00, 1'b0, 1'b0);
    tick();
    check("t5.drain", 32'(bus.valid_o), 32'd0);

    // test 6: reset mid-word discards the partial word
    drive(8'hE1, 1'b1, 1'b0); tick();
    drive(8'hE2, 1'b1, 1'b0); tick();
    rst_i = 1'b1;
    drive(8'hEE, 1'b1, 1'b0);
    #1;
    check("t6.ready_in_reset", 32'(bus.ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    #1;
    check("t6.valid", 32'(bus.valid_o), 32'd0);
    check("t6.data",  bus.data_o, 32'd0);
    check("t6.strb",  32'(bus.strb_o), 32'd0);
    drive(8'hF1, 1'b1, 1'b0); tick();
    drive(8'hF2, 1'b1, 1'b0); tick();
    drive(8'hF3, 1'b1, 1'b0); tick();
    check("t6.no_early", 32'(bus.valid_o), 32'd0);
    drive(8'hF4, 1'b1, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b0);
    check_word("t6.fresh", 32'hF4F3F2F1, 4'b1111, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
